// File: rtl/mod_arith_pkg.sv
// Shared types and constants for mod_exp_engine and its bit-serial
// Montgomery multiplier.
package mod_arith_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CHECK     = 4'd1,
    ST_TO_MONT   = 4'd2,
    ST_ONE_MONT  = 4'd3,
    ST_SCAN      = 4'd4,
    ST_SQR       = 4'd5,
    ST_MUL       = 4'd6,
    ST_FROM_MONT = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_EVEN_MOD   = 2'd1,
    ERR_SMALL_MOD  = 2'd2,
    ERR_BASE_RANGE = 2'd3
  } err_code_e;

  // Radix-2 steps per Montgomery product: one per bit of the multiplier operand.
  function automatic int mm_iterations(input int width);
    return width;
  endfunction

endpackage

// File: rtl/mont_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-WIDTH mod n.
// One dispatch cycle, WIDTH reduction steps, one conditional-subtract cycle.
module mont_mul_serial
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int ITERS = mm_iterations(WIDTH);
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH+1:0] t_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;
  logic [WIDTH+1:0] sum_s;
  logic [WIDTH+1:0] red_s;
  logic [WIDTH+1:0] t_d;

  // t stays below 2n, so t + b + n < 4n fits in WIDTH+2 bits.
  always_comb begin
    sum_s = t_q + (a_q[0] ? {2'b00, b_q} : {(WIDTH+2){1'b0}});
    red_s = sum_s[0] ? (sum_s + {2'b00, n_q}) : sum_s;
    t_d   = red_s >> 1;
  end

  // Operand capture on dispatch, then one reduction step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      t_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      n_q    <= n;
      t_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      t_q   <= t_d;
      a_q   <= a_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST_ITER) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  // The final subtract is the done cycle itself, so the caller consumes p
  // without another register stage.
  assign p    = WIDTH'((t_q >= {2'b00, n_q}) ? (t_q - {2'b00, n_q}) : t_q);
  assign done = done_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine (left-to-right square-and-multiply, Montgomery
// domain). Define MOD_EXP_CONST_TIME_EN for fixed, data-independent latency.
module mod_exp_engine
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] r2_mod,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  state_e           state_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] r2_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] bm_q;
  logic [CNT_W-1:0] idx_q;
  logic             mm_start_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] mm_a_s;
  logic [WIDTH-1:0] mm_b_s;
  logic [WIDTH-1:0] mm_p_s;
  logic             mm_done_s;
  err_code_e        err_code_s;
  logic             exp_bit_s;
  logic             last_bit_s;
  logic             take_mul_s;

  function automatic logic [CNT_W-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = v[i] ? CNT_W'(i) : idx;
    end
    return idx;
  endfunction

  // Operand validation, evaluated while in CHECK.
  always_comb begin
    err_code_s = ERR_NONE;
    if (mod_q[0] == 1'b0) begin
      err_code_s = ERR_EVEN_MOD;
    end else if (mod_q <= WIDTH'(1)) begin
      err_code_s = ERR_SMALL_MOD;
    end else if (base_q >= mod_q) begin
      err_code_s = ERR_BASE_RANGE;
    end else begin
      err_code_s = ERR_NONE;
    end
  end

  // Current exponent bit and whether its multiply step is executed.
  always_comb begin
    exp_bit_s  = |(exp_q & (WIDTH'(1) << idx_q));
    last_bit_s = (idx_q == '0);
`ifdef MOD_EXP_CONST_TIME_EN
    take_mul_s = 1'b1;
`else
    take_mul_s = exp_bit_s;
`endif
  end

  // Single shared multiplier; operands selected by the phase of the walk.
  always_comb begin
    mm_a_s = '0;
    mm_b_s = '0;
    case (state_q)
      ST_TO_MONT:   begin mm_a_s = base_q;    mm_b_s = r2_q;      end
      ST_ONE_MONT:  begin mm_a_s = WIDTH'(1); mm_b_s = r2_q;      end
      ST_SQR:       begin mm_a_s = acc_q;     mm_b_s = acc_q;     end
      ST_MUL:       begin mm_a_s = acc_q;     mm_b_s = bm_q;      end
      ST_FROM_MONT: begin mm_a_s = acc_q;     mm_b_s = WIDTH'(1); end
      default:      begin mm_a_s = '0;        mm_b_s = '0;        end
    endcase
  end

  mont_mul_serial #(
    .WIDTH (WIDTH)
  ) u_mm (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mm_start_q),
    .a     (mm_a_s),
    .b     (mm_b_s),
    .n     (mod_q),
    .done  (mm_done_s),
    .p     (mm_p_s)
  );

  // Sequencer: validation, domain conversions and the square-and-multiply walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      r2_q       <= '0;
      acc_q      <= '0;
      bm_q       <= '0;
      idx_q      <= '0;
      mm_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base;
            exp_q   <= exponent;
            mod_q   <= modulus;
            r2_q    <= r2_mod;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (err_code_s != ERR_NONE) begin
            err_q    <= 1'b1;
            result_q <= '0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
`ifdef MOD_EXP_CONST_TIME_EN
            mm_start_q <= 1'b1;
            state_q    <= ST_TO_MONT;
`else
            if (exp_q == '0) begin
              result_q <= WIDTH'(1);
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              mm_start_q <= 1'b1;
              state_q    <= ST_TO_MONT;
            end
`endif
          end
        end
        ST_TO_MONT: begin
          if (mm_done_s) begin
            bm_q       <= mm_p_s;
            mm_start_q <= 1'b1;
            state_q    <= ST_ONE_MONT;
          end
        end
        ST_ONE_MONT: begin
          if (mm_done_s) begin
            acc_q   <= mm_p_s;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
`ifdef MOD_EXP_CONST_TIME_EN
          idx_q <= CNT_W'(WIDTH - 1);
`else
          idx_q <= msb_index(exp_q);
`endif
          mm_start_q <= 1'b1;
          state_q    <= ST_SQR;
        end
        ST_SQR: begin
          if (mm_done_s) begin
            acc_q      <= mm_p_s;
            mm_start_q <= 1'b1;
            if (take_mul_s) begin
              state_q <= ST_MUL;
            end else if (last_bit_s) begin
              state_q <= ST_FROM_MONT;
            end else begin
              idx_q   <= idx_q - CNT_W'(1);
              state_q <= ST_SQR;
            end
          end
        end
        ST_MUL: begin
          // A zero bit only reaches here in the constant-time build; drop its product.
          if (mm_done_s) begin
            if (exp_bit_s) begin
              acc_q <= mm_p_s;
            end
            mm_start_q <= 1'b1;
            if (last_bit_s) begin
              state_q <= ST_FROM_MONT;
            end else begin
              idx_q   <= idx_q - CNT_W'(1);
              state_q <= ST_SQR;
            end
          end
        end
        ST_FROM_MONT: begin
          if (mm_done_s) begin
            result_q <= mm_p_s;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine at WIDTH=16 with a scoreboard of
// expected result/err/latency; honours MOD_EXP_CONST_TIME_EN for latency.
module tb_mod_exp_engine;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0;
  logic [W-1:0] exponent = '0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] r2_mod = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] res;
    logic         err;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0 = 0;

  mod_exp_engine #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .r2_mod   (r2_mod),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                              input logic [W-1:0] m);
    longint unsigned r;
    r = 1;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % longint'(m);
      if (e[i]) r = (r * longint'(b)) % longint'(m);
    end
    return W'(r);
  endfunction

  function automatic int ref_latency(input logic [W-1:0] e);
    int n_ops;
`ifdef MOD_EXP_CONST_TIME_EN
    n_ops = 2 * W;
`else
    int l;
    int p;
    l = 0;
    p = 0;
    for (int i = 0; i < W; i++) begin
      if (e[i]) begin
        p++;
        l = i + 1;
      end
    end
    if (e == '0) return 2;
    n_ops = l + p;
`endif
    return (3 + n_ops) * (W + 2) + 3;
  endfunction

  function automatic logic [W-1:0] ref_r2(input logic [W-1:0] m);
    longint unsigned one;
    one = 1;
    if (m == '0) return '0;
    return W'((one << (2 * W)) % longint'(m));
  endfunction

  task automatic issue(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                       input logic [W-1:0] res, input logic er);
    exp_t x;
    x.res = res;
    x.err = er;
    x.lat = er ? 2 : ref_latency(e);
    sb.push_back(x);
    @(negedge clk);
    base     = b;
    exponent = e;
    modulus  = m;
    r2_mod   = ref_r2(m);
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic await_done(output logic [W-1:0] r, output logic e, output int lat, output bit to);
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    r   = result;
    e   = err;
    lat = cyc - t0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_vectors();
    vec_t v [10];
    exp_t x;
    logic [W-1:0] r;
    logic e;
    int lat;
    bit to;
    v = '{
      '{16'd65,   16'd17,     16'd3233,   16'd2790, 1'b0},
      '{16'd2,    16'd16,     16'd65521,  16'd15,   1'b0},
      '{16'd3,    16'd65520,  16'd65521,  16'd1,    1'b0},
      '{16'd123,  16'd0,      16'd3233,   16'd1,    1'b0},
      '{16'd5,    16'd3,      16'h1000,   16'd0,    1'b1},
      '{16'd3233, 16'd3,      16'd3233,   16'd0,    1'b1},
      '{16'd4,    16'd3,      16'd1,      16'd0,    1'b1},
      '{16'd65,   16'd1,      16'd3233,   16'd65,   1'b0},
      '{16'd1,    16'hFFFF,   16'd3233,   16'd1,    1'b0},
      '{16'd3232, 16'd2,      16'd3233,   16'd1,    1'b0}
    };
    foreach (v[k]) begin
      issue(v[k].b, v[k].e, v[k].m, v[k].res, v[k].err);
      await_done(r, e, lat, to);
      x = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL vec%0d_timeout: no done after %0d cycles", k, lat); end
      total++; if (r !== x.res) begin bad++; $display("FAIL vec%0d_result: got %0d want %0d", k, r, x.res); end
      total++; if (e !== x.err) begin bad++; $display("FAIL vec%0d_err: got %b want %b", k, e, x.err); end
      total++; if (lat !== x.lat) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, x.lat); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    logic [W-1:0] r;
    logic e;
    int lat;
    bit to;
    issue(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
    start    = 1'b1;
    base     = 16'd99;
    exponent = 16'd3;
    modulus  = 16'd77;
    r2_mod   = 16'd11;
    repeat (3) @(negedge clk);
    start = 1'b0;
    await_done(r, e, lat, to);
    x = sb.pop_front();
    total++; if (to) begin bad++; $display("FAIL b2b_timeout: no done after %0d cycles", lat); end
    total++; if (r !== x.res) begin bad++; $display("FAIL b2b_result: got %0d want %0d", r, x.res); end
    total++; if (lat !== x.lat) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, x.lat); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_done: got %b want 1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_after: got busy=%b done=%b want 0 0", busy, done);
    end
    total++; if (result !== 16'd2790) begin bad++; $display("FAIL b2b_hold: got %0d want 2790", result); end
    issue(16'd2, 16'd16, 16'd65521, 16'd15, 1'b0);
    await_done(r, e, lat, to);
    x = sb.pop_front();
    total++; if (to) begin bad++; $display("FAIL b2b2_timeout: no done after %0d cycles", lat); end
    total++; if (r !== x.res) begin bad++; $display("FAIL b2b2_result: got %0d want %0d", r, x.res); end
    total++; if (lat !== x.lat) begin bad++; $display("FAIL b2b2_latency: got %0d want %0d", lat, x.lat); end
  endtask

  task automatic test_reset_abort();
    exp_t x;
    logic [W-1:0] r;
    logic e;
    int lat;
    bit to;
    issue(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);
    repeat (45) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0", busy, done);
    end
    total++; if (result !== '0 || err !== 1'b0) begin
      bad++; $display("FAIL abort_data: got result=%0d err=%b want 0 0", result, err);
    end
    x = sb.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_nodone: got %b want 0", done); end
    issue(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0);
    await_done(r, e, lat, to);
    x = sb.pop_front();
    total++; if (to) begin bad++; $display("FAIL restart_timeout: no done after %0d cycles", lat); end
    total++; if (r !== x.res) begin bad++; $display("FAIL restart_result: got %0d want %0d", r, x.res); end
    total++; if (lat !== x.lat) begin bad++; $display("FAIL restart_latency: got %0d want %0d", lat, x.lat); end
  endtask

  task automatic test_random();
    exp_t x;
    logic [W-1:0] r;
    logic e;
    int lat;
    bit to;
    logic [W-1:0] m;
    logic [W-1:0] b;
    logic [W-1:0] ex;
    for (int k = 0; k < 60; k++) begin
      m  = W'($urandom_range(3, 65535)) | 16'd1;
      b  = W'($urandom_range(0, int'(m) - 1));
      ex = W'($urandom);
      issue(b, ex, m, ref_modexp(b, ex, m), 1'b0);
      await_done(r, e, lat, to);
      x = sb.pop_front();
      total++; if (to) begin bad++; $display("FAIL rnd%0d_timeout: no done after %0d cycles", k, lat); end
      total++; if (r !== x.res || e !== x.err) begin
        bad++; $display("FAIL rnd%0d_result: b=%0d e=%0d m=%0d got %0d/%b want %0d/%b", k, b, ex, m, r, e, x.res, x.err);
      end
      total++; if (lat !== x.lat) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, x.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
